// File: rtl/softplus_pla_pkg.sv
// Constants shared by the forward softplus PLA unit and its gradient unit.
// Q8.8 breakpoints, per-slice slopes, and the derived piecewise-constant gradient table.
package softplus_pla_pkg;

  localparam int DATA_W = 16;
  localparam int SLICES = 4;
  localparam int FP     = 8;
  localparam int IDX_W  = $clog2(SLICES + 2);

  localparam int BREAKPOINTS [SLICES+1] = '{-1536, -768, 0, 768, 1536};
  localparam int SLOPES      [SLICES]   = '{4, 55, 201, 252};

  // Zero below the first breakpoint, and the top slice's slope reused above the last one.
  localparam int GRAD_SLOPES [SLICES+2] =
    '{0, SLOPES[0], SLOPES[1], SLOPES[2], SLOPES[3], SLOPES[SLICES-1]};

endpackage

// File: rtl/softplus_slope_sel.sv
// Combinational slope selector: thermometer compare of x against the breakpoints,
// then priority-encode to a slice index and its gradient slope.
module softplus_slope_sel
  import softplus_pla_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] x,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] slope
);

  logic [SLICES:0] thermo;

  always_comb begin
    for (int i = 0; i <= SLICES; i++) begin
      thermo[i] = $signed(x) > WIDTH'(BREAKPOINTS[i]);
    end
  end

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    idx   = '0;
    slope = '0;
    for (int i = 0; i <= SLICES; i++) begin
      if (thermo[i]) begin
        idx   = IDX_W'(i + 1);
        slope = WIDTH'(GRAD_SLOPES[i + 1]);
      end
    end
  end

endmodule

// File: rtl/softplus4_grad_pla.sv
// Backward pass of the 4-slice softplus PLA: dx = g * s(x), Q8.8, three-stage
// pipeline with a single global advance enable and valid/ready on both sides.
module softplus4_grad_pla #(
  parameter int WIDTH  = softplus_pla_pkg::DATA_W,
  parameter int SLICES = softplus_pla_pkg::SLICES,
  parameter int FP     = softplus_pla_pkg::FP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] g,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dx
);

  localparam int IDX_W = $clog2(SLICES + 2);

  logic                      en;
  logic                      s1_valid, s2_valid, s3_valid;
  logic        [WIDTH-1:0]   s1_x;
  logic signed [WIDTH-1:0]   s1_g;
  logic        [IDX_W-1:0]   s2_idx;
  logic signed [2*WIDTH-1:0] s2_p;
  logic        [IDX_W-1:0]   sel_idx;
  logic        [WIDTH-1:0]   sel_slope;

  softplus_slope_sel #(.WIDTH(WIDTH)) u_slope_sel (
    .x     (s1_x),
    .idx   (sel_idx),
    .slope (sel_slope)
  );

  // The whole pipe advances together; it only freezes when S3 holds an unaccepted result.
  assign en        = !s3_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = s3_valid;

  // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
  // NOTE: data registers are cleared on reset too, so dx reads 0 until the first valid result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_x     <= '0;
      s1_g     <= '0;
      s2_idx   <= '0;
      s2_p     <= '0;
      dx       <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      if (in_valid) begin
        s1_x <= x;
        s1_g <= g;
      end
      if (s1_valid) begin
        s2_idx <= sel_idx;
        s2_p   <= s1_g * $signed(sel_slope);
      end
      // dx only moves on a valid advance so it keeps its last value across bubbles.
      // Index 0 is the flat region, where the gradient is exactly zero.
      if (s2_valid) begin
        dx <= (s2_idx == '0) ? '0 : WIDTH'(s2_p >>> FP);
      end
    end
  end

endmodule

// File: tb/tb_softplus4_grad_pla.sv
// Scoreboard bench for softplus4_grad_pla: stimulus pushes expected dx from an
// arithmetic reference; an independent monitor pops and compares on each output handshake.
module tb_softplus4_grad_pla;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] g = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] dx;

  softplus4_grad_pla dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .g         (g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dx        (dx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] exp;
    int           cyc;
    bit           lat;
  } item_t;

  item_t q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    accepts = 0;
  int    outputs = 0;
  bit    check_lat = 1'b0;
  bit    rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: gradient of the PLA softplus is the slope of the slice containing x.
  function automatic logic [W-1:0] model(input int xv, input int gv);
    int s;
    if (xv <= -1536)      s = 0;
    else if (xv <= -768)  s = 4;
    else if (xv <= 0)     s = 55;
    else if (xv <= 768)   s = 201;
    else                  s = 252;
    return W'((gv * s) >>> 8);
  endfunction

  task automatic send(input int xv, input int gv);
    item_t it;
    int    n = 0;
    in_valid = 1'b1;
    x = W'(xv);
    g = W'(gv);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
    end else begin
      it.exp = model(xv, gv);
      it.cyc = cyc;
      it.lat = check_lat;
      q.push_back(it);
      accepts++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    item_t it;
    if (rst_n && out_valid && out_ready) begin
      outputs++;
      if (q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        it = q.pop_front();
        check("dx", dx, it.exp);
        if (it.lat) check("latency", cyc - it.cyc, 3);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) #1 out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs [13] = '{-2000, -1000, -767, 1, 1000, 2000,
                    -1536, -768, 0, 768, 1536, 32767, -32768};
    logic [W-1:0] hold;
    logic signed [W-1:0] rx, rg;

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_dx", dx, 0);
    rst_n = 1'b1;
    #1 check("reset_in_ready", in_ready, 1);

    // Slope regions and boundaries with unit gradient, unstalled.
    out_ready = 1'b1;
    check_lat = 1'b1;
    foreach (xs[i]) send(xs[i], 256);
    send(100, -1);
    send(2000, -512);
    send(500, 32767);
    send(500, -32768);
    drain();
    check_lat = 1'b0;

    // Back-to-back stream with downstream stalled for six cycles.
    fork
      begin
        for (int i = 0; i < 8; i++) send(i * 300 - 1200, 256 + i * 37);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        hold = dx;
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_dx_hold", dx, hold);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Bubbles with random downstream readiness.
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rx = W'($urandom);
      rg = W'($urandom);
      send(rx, rg);
      @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    check("accepts_eq_outputs", outputs, accepts);

    // Reset with three items in flight.
    for (int i = 0; i < 3; i++) send(1000 - i * 900, 700);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_dx", dx, 0);
    accepts -= q.size();
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_lat = 1'b1;
    send(-900, 1234);
    drain();
    check_lat = 1'b0;
    check("final_accepts_eq_outputs", outputs, accepts);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
